// File: rtl/proc_pkg.sv
// Shared definitions for the single-issue instruction sequencer: FSM encoding,
// default instruction field layout (op|src0|src1|dst0|dst1, MSB first) and destination port indices.
package proc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OPERAND = 2'd1,
        ST_EXEC    = 2'd2,
        ST_WRITE   = 2'd3
    } state_e;

    localparam int OPCODE_W_DEF = 2;
    localparam int SRC0_W_DEF   = 2;
    localparam int SRC1_W_DEF   = 2;
    localparam int DST0_W_DEF   = 1;
    localparam int DST1_W_DEF   = 1;

    localparam int DST1_LSB_DEF   = 0;
    localparam int DST0_LSB_DEF   = DST1_LSB_DEF + DST1_W_DEF;
    localparam int SRC1_LSB_DEF   = DST0_LSB_DEF + DST0_W_DEF;
    localparam int SRC0_LSB_DEF   = SRC1_LSB_DEF + SRC1_W_DEF;
    localparam int OPCODE_LSB_DEF = SRC0_LSB_DEF + SRC0_W_DEF;

    localparam int DST_NEIGH = 0;
    localparam int DST_BUS   = 1;
    localparam int NUM_DST   = 2;

endpackage

// File: rtl/proc_inst_decode.sv
// Combinational split of an instruction word into its fields; the lowest field
// (dst1) sits at bit 0 and each field above starts where the previous one ends.
module proc_inst_decode
    import proc_pkg::*;
#(
    parameter int INST_WIDTH     = 8,
    parameter int OPCODE_WIDTH   = OPCODE_W_DEF,
    parameter int SRC0_IDX_WIDTH = SRC0_W_DEF,
    parameter int SRC1_IDX_WIDTH = SRC1_W_DEF,
    parameter int DST0_IDX_WIDTH = DST0_W_DEF,
    parameter int DST1_IDX_WIDTH = DST1_W_DEF
) (
    input  logic [INST_WIDTH-1:0]     inst,
    output logic [OPCODE_WIDTH-1:0]   op,
    output logic [SRC0_IDX_WIDTH-1:0] src0,
    output logic [SRC1_IDX_WIDTH-1:0] src1,
    output logic [DST0_IDX_WIDTH-1:0] dst0,
    output logic [DST1_IDX_WIDTH-1:0] dst1
);

    localparam int DST1_LSB = 0;
    localparam int DST0_LSB = DST1_LSB + DST1_IDX_WIDTH;
    localparam int SRC1_LSB = DST0_LSB + DST0_IDX_WIDTH;
    localparam int SRC0_LSB = SRC1_LSB + SRC1_IDX_WIDTH;
    localparam int OP_LSB   = SRC0_LSB + SRC0_IDX_WIDTH;

    assign op   = inst[OP_LSB   +: OPCODE_WIDTH];
    assign src0 = inst[SRC0_LSB +: SRC0_IDX_WIDTH];
    assign src1 = inst[SRC1_LSB +: SRC1_IDX_WIDTH];
    assign dst0 = inst[DST0_LSB +: DST0_IDX_WIDTH];
    assign dst1 = inst[DST1_LSB +: DST1_IDX_WIDTH];

endmodule

// File: rtl/proc_sequencer.sv
// Sequencer that fetches one instruction, gathers its operands from source FIFOs,
// runs them through an external combinational ALU and writes the result to 0..2 destinations.
module proc_sequencer
    import proc_pkg::*;
#(
    parameter int DATA_WIDTH     = 4,
    parameter int INST_WIDTH     = 8,
    parameter int OPCODE_WIDTH   = OPCODE_W_DEF,
    parameter int SRC0_IDX_WIDTH = SRC0_W_DEF,
    parameter int SRC1_IDX_WIDTH = SRC1_W_DEF,
    parameter int DST0_IDX_WIDTH = DST0_W_DEF,
    parameter int DST1_IDX_WIDTH = DST1_W_DEF,
    parameter int NUM_SRC        = 2,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           ctrl_empty,
    input  logic [INST_WIDTH-1:0]          ctrl_data,
    output logic                           ctrl_deq,
    input  logic [NUM_SRC-1:0]             src_empty,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]  src_data,
    output logic [NUM_SRC-1:0]             src_deq,
    input  logic [NUM_DST-1:0]             dst_full,
    output logic [NUM_DST-1:0]             dst_enq,
    output logic [DATA_WIDTH-1:0]          dst_data,
    output logic                           alu_enable,
    output logic [OPCODE_WIDTH-1:0]        alu_op_code,
    output logic [DATA_WIDTH-1:0]          alu_op0,
    output logic [DATA_WIDTH-1:0]          alu_op1,
    input  logic [DATA_WIDTH-1:0]          alu_out,
    output logic                           busy,
    output logic                           illegal_src,
    output logic [CNT_WIDTH-1:0]           retired_cnt,
    output logic [CNT_WIDTH-1:0]           stall_cnt
);

    generate
        if (INST_WIDTH != OPCODE_WIDTH + SRC0_IDX_WIDTH + SRC1_IDX_WIDTH + DST0_IDX_WIDTH + DST1_IDX_WIDTH) begin : g_bad_inst_width
            $error("proc_sequencer: INST_WIDTH does not match the sum of the field widths");
        end
        if (NUM_SRC < 1 || NUM_SRC > (1 << SRC0_IDX_WIDTH)) begin : g_bad_num_src
            $error("proc_sequencer: NUM_SRC out of range");
        end
    endgenerate

    state_e                  state_q, state_d;
    logic [INST_WIDTH-1:0]   inst_q, inst_d;
    logic [DATA_WIDTH-1:0]   op0_q, op0_d, op1_q, op1_d, result_q, result_d;
    logic                    illegal_q, illegal_d;
    logic [CNT_WIDTH-1:0]    retired_q, retired_d, stall_q, stall_d;

    logic [OPCODE_WIDTH-1:0]   op;
    logic [SRC0_IDX_WIDTH-1:0] src0;
    logic [SRC1_IDX_WIDTH-1:0] src1;
    logic [DST0_IDX_WIDTH-1:0] dst0;
    logic [DST1_IDX_WIDTH-1:0] dst1;

    proc_inst_decode #(
        .INST_WIDTH     (INST_WIDTH),
        .OPCODE_WIDTH   (OPCODE_WIDTH),
        .SRC0_IDX_WIDTH (SRC0_IDX_WIDTH),
        .SRC1_IDX_WIDTH (SRC1_IDX_WIDTH),
        .DST0_IDX_WIDTH (DST0_IDX_WIDTH),
        .DST1_IDX_WIDTH (DST1_IDX_WIDTH)
    ) u_decode (
        .inst (inst_q),
        .op   (op),
        .src0 (src0),
        .src1 (src1),
        .dst0 (dst0),
        .dst1 (dst1)
    );

    logic                    src_bad, src_ready, dst_ready;
    logic [NUM_SRC-1:0]      src_hit;
    logic [DATA_WIDTH-1:0]   src_val0, src_val1;
    logic [NUM_DST-1:0]      dst_set;

    always_comb begin
        state_d    = state_q;
        inst_d     = inst_q;
        op0_d      = op0_q;
        op1_d      = op1_q;
        result_d   = result_q;
        illegal_d  = illegal_q;
        retired_d  = retired_q;
        stall_d    = stall_q;
        ctrl_deq   = 1'b0;
        src_deq    = '0;
        dst_enq    = '0;
        alu_enable = 1'b0;

        // Both operands referencing the same source collapse onto one hit bit, so it pops once.
        src_bad  = (int'(src0) >= NUM_SRC) || (int'(src1) >= NUM_SRC);
        src_hit  = '0;
        src_val0 = '0;
        src_val1 = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (int'(src0) == i) begin
                src_hit[i] = 1'b1;
                src_val0   = src_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (int'(src1) == i) begin
                src_hit[i] = 1'b1;
                src_val1   = src_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        src_ready = ((src_hit & src_empty) == '0);

        dst_set            = '0;
        dst_set[DST_NEIGH] = |dst0;
        dst_set[DST_BUS]   = |dst1;
        dst_ready          = ((dst_set & dst_full) == '0);

        unique case (state_q)
            ST_IDLE: begin
                // Gated by reset so the instruction FIFO is never popped while held in reset.
                if (!ctrl_empty && reset) begin
                    ctrl_deq = 1'b1;
                    inst_d   = ctrl_data;
                    state_d  = ST_OPERAND;
                end
            end
            ST_OPERAND: begin
                if (src_bad) begin
                    illegal_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (src_ready) begin
                    src_deq = src_hit;
                    op0_d   = src_val0;
                    op1_d   = src_val1;
                    state_d = ST_EXEC;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
            end
            ST_EXEC: begin
                alu_enable = 1'b1;
                result_d   = alu_out;
                state_d    = ST_WRITE;
            end
            ST_WRITE: begin
                if (dst_ready) begin
                    dst_enq   = dst_set;
                    retired_d = retired_q + 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            inst_q    <= '0;
            op0_q     <= '0;
            op1_q     <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            op0_q     <= op0_d;
            op1_q     <= op1_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
            stall_q   <= stall_d;
        end
    end

    assign alu_op_code = op;
    assign alu_op0     = op0_q;
    assign alu_op1     = op1_q;
    assign dst_data    = result_q;
    assign busy        = (state_q != ST_IDLE);
    assign illegal_src = illegal_q;
    assign retired_cnt = retired_q;
    assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_proc_sequencer.sv
// Bench for proc_sequencer: directed instructions with hand-computed results; a monitor
// pops expected source pops, ALU calls and enqueues from scoreboard queues.
module tb_proc_sequencer;

    localparam int DW = 4;
    localparam int IW = 8;
    localparam int NS = 2;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            ctrl_empty;
    logic [IW-1:0]   ctrl_data;
    logic            ctrl_deq;
    logic [NS-1:0]   src_empty;
    logic [NS*DW-1:0] src_data;
    logic [NS-1:0]   src_deq;
    logic [1:0]      dst_full;
    logic [1:0]      dst_enq;
    logic [DW-1:0]   dst_data;
    logic            alu_enable;
    logic [1:0]      alu_op_code;
    logic [DW-1:0]   alu_op0, alu_op1, alu_out;
    logic            busy, illegal_src;
    logic [CW-1:0]   retired_cnt, stall_cnt;

    proc_sequencer #(
        .DATA_WIDTH (DW), .INST_WIDTH (IW), .NUM_SRC (NS), .CNT_WIDTH (CW)
    ) dut (
        .clk (clk), .reset (reset),
        .ctrl_empty (ctrl_empty), .ctrl_data (ctrl_data), .ctrl_deq (ctrl_deq),
        .src_empty (src_empty), .src_data (src_data), .src_deq (src_deq),
        .dst_full (dst_full), .dst_enq (dst_enq), .dst_data (dst_data),
        .alu_enable (alu_enable), .alu_op_code (alu_op_code),
        .alu_op0 (alu_op0), .alu_op1 (alu_op1), .alu_out (alu_out),
        .busy (busy), .illegal_src (illegal_src),
        .retired_cnt (retired_cnt), .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    // External ALU: 0 add, 1 sub, 2 and, 3 xor.
    always_comb begin
        alu_out = '0;
        case (alu_op_code)
            2'd0: alu_out = alu_op0 + alu_op1;
            2'd1: alu_out = alu_op0 - alu_op1;
            2'd2: alu_out = alu_op0 & alu_op1;
            default: alu_out = alu_op0 ^ alu_op1;
        endcase
    end

    typedef struct { logic [1:0] mask; logic [3:0] data; int lat; } enq_t;
    typedef struct { logic [1:0] op; logic [3:0] a; logic [3:0] b; } alu_t;

    enq_t       exp_enq[$];
    alu_t       exp_alu[$];
    logic [1:0] exp_src[$];
    logic [3:0] q0[$];
    logic [3:0] q1[$];

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Source FIFO model: a pop seen before the edge takes effect just after it.
    initial begin
        logic [1:0] pend;
        src_empty = 2'b11;
        src_data  = '0;
        forever begin
            @(negedge clk);
            pend = src_deq;
            @(posedge clk);
            #1;
            if (pend[0] && q0.size() > 0) void'(q0.pop_front());
            if (pend[1] && q1.size() > 0) void'(q1.pop_front());
            src_empty[0]   = (q0.size() == 0);
            src_empty[1]   = (q1.size() == 0);
            src_data[3:0]  = (q0.size() > 0) ? q0[0] : 4'h0;
            src_data[7:4]  = (q1.size() > 0) ? q1[0] : 4'h0;
        end
    end

    // Monitor: every strobe must match the next scoreboard entry.
    initial begin
        int   cyc;
        int   fetch_cyc;
        enq_t e;
        alu_t a;
        cyc = 0;
        fetch_cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (ctrl_deq) fetch_cyc = cyc;
            if (src_deq != 2'b00) begin
                chk("src_deq_to_empty", src_deq & src_empty, 0);
                if (exp_src.size() == 0) chk("src_deq_unexpected", src_deq, 0);
                else chk("src_deq_mask", src_deq, exp_src.pop_front());
            end
            if (alu_enable) begin
                if (exp_alu.size() == 0) chk("alu_unexpected", alu_enable, 0);
                else begin
                    a = exp_alu.pop_front();
                    chk("alu_op_code", alu_op_code, a.op);
                    chk("alu_op0", alu_op0, a.a);
                    chk("alu_op1", alu_op1, a.b);
                end
            end
            if (dst_enq != 2'b00) begin
                chk("dst_enq_to_full", dst_enq & dst_full, 0);
                if (exp_enq.size() == 0) chk("dst_enq_unexpected", dst_enq, 0);
                else begin
                    e = exp_enq.pop_front();
                    chk("dst_enq_mask", dst_enq, e.mask);
                    chk("dst_data", dst_data, e.data);
                    chk("enq_latency", cyc - fetch_cyc, e.lat);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] inst);
        int n;
        ctrl_data  = inst;
        ctrl_empty = 1'b0;
        n = 0;
        @(negedge clk);
        while (!ctrl_deq && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ctrl_deq_seen", ctrl_deq, 1);
        tick();
        ctrl_empty = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", busy, 0);
        tick();
    endtask

    task automatic wait_alu();
        int n;
        n = 0;
        @(negedge clk);
        while (!alu_enable && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("alu_enable_seen", alu_enable, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, vectors %0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        ctrl_empty = 1'b0;
        ctrl_data  = 8'h07;
        dst_full   = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ctrl_deq", ctrl_deq, 0);
        chk("rst_illegal", illegal_src, 0);
        chk("rst_retired", retired_cnt, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_strobes", {alu_enable, src_deq, dst_enq}, 0);
        ctrl_empty = 1'b1;
        tick();
        reset = 1'b1;
        tick();

        // add src0=0 (3) + src1=1 (5) to both destinations
        q0.push_back(4'd3); q1.push_back(4'd5);
        exp_src.push_back(2'b11);
        exp_alu.push_back('{2'd0, 4'd3, 4'd5});
        exp_enq.push_back('{2'b11, 4'd8, 3});
        issue(8'h07);
        wait_idle();
        chk("t1_retired", retired_cnt, 1);
        chk("t1_stall", stall_cnt, 0);

        // sub 9 - 4 to neighbor only; src1 arrives after five stalled cycles
        q0.push_back(4'd9);
        exp_src.push_back(2'b11);
        exp_alu.push_back('{2'd1, 4'd9, 4'd4});
        exp_enq.push_back('{2'b01, 4'd5, 8});
        issue(8'h46);
        repeat (5) @(posedge clk);
        q1.push_back(4'd4);
        wait_idle();
        chk("t2_retired", retired_cnt, 2);
        chk("t2_stall", stall_cnt, 5);

        // and, operands swapped (src0=1, src1=0); bus full for three WRITE cycles
        dst_full = 2'b10;
        q0.push_back(4'hC); q1.push_back(4'hA);
        exp_src.push_back(2'b11);
        exp_alu.push_back('{2'd2, 4'hA, 4'hC});
        exp_enq.push_back('{2'b11, 4'h8, 6});
        issue(8'h93);
        wait_alu();
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        dst_full = 2'b00;
        wait_idle();
        chk("t3_retired", retired_cnt, 3);
        chk("t3_stall", stall_cnt, 8);

        // src0=3 is out of range: discarded, source head must survive
        q0.push_back(4'd7);
        issue(8'h33);
        wait_idle();
        chk("t4_illegal", illegal_src, 1);
        chk("t4_retired", retired_cnt, 3);
        chk("t4_q0_kept", q0.size(), 1);

        // xor 7 ^ 2 to bus only, following the discarded instruction
        q1.push_back(4'd2);
        exp_src.push_back(2'b11);
        exp_alu.push_back('{2'd3, 4'd7, 4'd2});
        exp_enq.push_back('{2'b10, 4'd5, 3});
        issue(8'hC5);
        wait_idle();
        chk("t4b_retired", retired_cnt, 4);
        chk("t4b_illegal_sticky", illegal_src, 1);

        // src0 == src1 == 0, head 6: single pop, 6 + 6
        q0.push_back(4'd6); q0.push_back(4'd1);
        exp_src.push_back(2'b01);
        exp_alu.push_back('{2'd0, 4'd6, 4'd6});
        exp_enq.push_back('{2'b01, 4'hC, 3});
        issue(8'h02);
        wait_idle();
        chk("t5_retired", retired_cnt, 5);
        chk("t5_q0_single_pop", q0.size(), 1);

        // no destinations: still retires
        exp_src.push_back(2'b01);
        exp_alu.push_back('{2'd1, 4'd1, 4'd1});
        issue(8'h40);
        wait_idle();
        chk("t6_retired", retired_cnt, 6);
        chk("t6_stall", stall_cnt, 8);

        // reset while blocked in WRITE
        dst_full = 2'b11;
        q0.push_back(4'd1); q1.push_back(4'd2);
        exp_src.push_back(2'b11);
        exp_alu.push_back('{2'd0, 4'd1, 4'd2});
        issue(8'h07);
        wait_alu();
        @(posedge clk);
        repeat (2) tick();
        reset = 1'b0;
        #1;
        chk("t7_busy", busy, 0);
        chk("t7_retired", retired_cnt, 0);
        chk("t7_stall", stall_cnt, 0);
        chk("t7_illegal", illegal_src, 0);
        chk("t7_enq", dst_enq, 0);
        tick();
        reset = 1'b1;
        dst_full = 2'b00;
        repeat (5) tick();
        chk("t7_busy_after", busy, 0);
        chk("t7_retired_after", retired_cnt, 0);

        chk("sb_enq_drained", exp_enq.size(), 0);
        chk("sb_alu_drained", exp_alu.size(), 0);
        chk("sb_src_drained", exp_src.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
